// File: rtl/dm_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
// Holds the fixed word width, FSM state encoding and latency counter width.
package dm_pkg;

    localparam int WORD_W = 16;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/dm_sram.sv
// Single-port synchronous word array with a registered read port.
// Ports: clk, rst_n (sync, active-low; clears read register only),
//        en/we/addr/wdata access strobe, rdata registered read data.
module dm_sram
    import dm_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [WORD_W-1:0]     wdata,
    output logic [WORD_W-1:0]     rdata
);

    logic [WORD_W-1:0] mem_q [2**DEPTH_LOG2];
    logic [WORD_W-1:0] rdata_q;
    logic [WORD_W-1:0] rdata_d;

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem_q[addr] <= wdata;
        end
    end

    // A store answers with zero data; the value otherwise holds.
    always_comb begin
        rdata_d = rdata_q;
        if (en) begin
            rdata_d = we ? '0 : mem_q[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dm_responder.sv
// Fixed-latency data-memory responder: one request in flight, valid/ready in.
// Ports: clk, rst_n (sync, active-low), req_* request, req_ready,
//        rsp_valid one-cycle pulse, rsp_rdata load data, stall to the core.
module dm_responder
    import dm_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              stall
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [DEPTH_LOG2-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]       wdata_q, wdata_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    accept;
    logic                    mem_en;
    logic                    unused_addr;

    // Upper address bits alias onto the array.
    assign unused_addr = ^req_addr[WORD_W-1:DEPTH_LOG2];

    assign req_ready = rst_n && (state_q != ST_WAIT);
    assign accept    = req_valid && req_ready;

    // In RESP the new request is taken at once, so the core is not held.
    assign stall = rst_n &&
                   ((state_q == ST_WAIT) ||
                    ((state_q != ST_WAIT) && req_valid &&
                     !((state_q == ST_RESP) && accept)));

    assign mem_en = rst_n && (state_q == ST_WAIT) && (cnt_q == '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        if (!rst_n) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            we_d    = 1'b0;
            addr_d  = '0;
            wdata_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_RESP: begin
                    state_d = ST_IDLE;
                    if (accept) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                        we_d    = req_we;
                        addr_d  = req_addr[DEPTH_LOG2-1:0];
                        wdata_d = req_wdata;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        rsp_valid_d = 1'b1;
                        state_d     = ST_RESP;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q     <= state_d;
        cnt_q       <= cnt_d;
        we_q        <= we_d;
        addr_q      <= addr_d;
        wdata_q     <= wdata_d;
        rsp_valid_q <= rsp_valid_d;
    end

    dm_sram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_sram (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (mem_en),
        .we   (we_q),
        .addr (addr_q),
        .wdata(wdata_q),
        .rdata(rsp_rdata)
    );

    assign rsp_valid = rsp_valid_q;

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
Memory-side responder for the CPU data-memory port. It accepts one load/store request at a time over a valid/ready handshake and models a fixed LATENCY-cycle backing SRAM. It returns read data or a write acknowledge with a one-cycle rsp_valid pulse, and drives a stall to the core while the request is outstanding. It replaces the zero-wait DM when multi-cycle memory timing is needed.

Parameters:
WORD_W, 16, data and address width (fixed ISA word; word-addressed)
DEPTH_LOG2, 10, log2 of array depth in words; only addr[DEPTH_LOG2-1:0] is used
LATENCY, 4, cycles from the accept edge to rsp_valid; legal range 1..15

Ports:
clk  in  1  clock, all state changes on rising edge
rst_n  in  1  reset, synchronous, active-low
req_valid  in  1  CPU presents a request
req_we  in  1  1 = store, 0 = load
req_addr  in  WORD_W  word address
req_wdata  in  WORD_W  store data
req_ready  out  1  responder can accept this cycle
rsp_valid  out  1  one-cycle pulse: load data valid / store committed
rsp_rdata  out  WORD_W  load data, valid when rsp_valid && load
stall  out  1  hold CPU pipeline; request not yet answered

Behaviour:
- States: IDLE, WAIT, RESP (encoded in 2-bit state register). Down-counter cnt is 4 bits.
- Reset (rst_n low at an edge): state=IDLE, cnt=0, rsp_valid=0, rsp_rdata=0, latched request cleared. Array contents are not reset.
- While rst_n is low, req_ready=0 and stall=0 combinationally.
- Reset mid-WAIT drops the pending request. A store in WAIT is not committed.
- req_ready=1 in IDLE and RESP, 0 in WAIT. Accept = req_valid && req_ready at a rising edge.
- On accept: latch we/addr/wdata, cnt <= LATENCY-1, state <= WAIT. req_* are ignored until the next accept; deasserting or changing them in WAIT has no effect.
- WAIT, cnt != 0: cnt <= cnt-1.
- WAIT, cnt == 0: perform the access on this edge.
  - Store: array[addr] <= wdata, rsp_rdata <= 0.
  - Load: rsp_rdata <= array[addr].
  - Then rsp_valid <= 1, state <= RESP.
- Timing: accept at edge k, so rsp_valid is high in the cycle following edge k+LATENCY, for exactly one cycle.
- RESP: rsp_valid <= 0 at the next edge.
  - If a new request is accepted on that edge (back-to-back): state <= WAIT.
  - Otherwise: state <= IDLE.
  - Sustained throughput is one request per LATENCY+1 cycles.
- rsp_rdata holds its value until the next response or reset.
- stall (combinational) = rst_n && ((state==WAIT) || (state!=WAIT && req_valid && !accepting_this_response)). Concretely:
  - 1 in IDLE with req_valid.
  - 1 throughout WAIT.
  - 0 in RESP, so the core retires the answered instruction.
  - 0 in IDLE without req_valid.
- In RESP, a concurrently presented new request is accepted and does not raise stall in that cycle. stall rises the following cycle (WAIT).
- Ordering: the store commits before its rsp_valid, so a load issued after a store to the same address returns the new data.
- Address aliasing: upper address bits above DEPTH_LOG2 are ignored; addresses wrap modulo 2^DEPTH_LOG2.
- No error response. Requests are never dropped except by reset.

Decomposition:
- Package dm_pkg: WORD_W, state enum (ST_IDLE=0, ST_WAIT=1, ST_RESP=2), CNT_W=4.
- Sub-module dm_sram: single-port synchronous array with one write port and one registered read port. Enable is asserted only at the WAIT/cnt==0 edge.
- dm_responder holds the FSM, counter, request latch and handshake logic.

Test Plan:
- Reset then idle, no req_valid -> req_ready=1, stall=0, rsp_valid=0, rsp_rdata=0 for 20 cycles.
- Store addr 0x0010 data 0xBEEF, LATENCY=4; accept at edge k -> rsp_valid only in the cycle after edge k+4. Then load 0x0010 -> rsp_rdata=0xBEEF.
- Back-to-back: in the RESP cycle of a load, present a store to 0x0011 data 0x1234 -> accepted that edge; next rsp_valid comes 4 cycles later; a following load of 0x0011 returns 0x1234.
- Aliasing, DEPTH_LOG2=10: store 0x0405 data 0x00AA, then load 0x0005 -> rsp_rdata=0x00AA.
- Change req_addr/req_wdata every cycle during WAIT -> the response reflects the values latched at accept only.
- Assert rst_n=0 for one edge during WAIT of a store to 0x0020 data 0x5555 (prior content 0x0000) -> state IDLE, no rsp_valid; a later load of 0x0020 returns 0x0000. Repeat with LATENCY=1: rsp_valid one cycle after the accept edge.
